// File: rtl/output_port_arbiter_if.sv
// Bundle of the arbiter's FIFO-side and link-side signals.
// master: the arbiter. slave: the FIFOs and the downstream link.
interface output_port_arbiter_if #(
  parameter int N_INPUTS   = 4,
  parameter int DATA_WIDTH = 64
);
  localparam int GW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  logic [N_INPUTS-1:0]                 in_empty;
  logic [N_INPUTS-1:0][DATA_WIDTH-1:0] in_data;
  logic [N_INPUTS-1:0]                 in_tail;
  logic [N_INPUTS-1:0]                 in_pop;
  logic                                out_valid;
  logic                                out_ready;
  logic [DATA_WIDTH-1:0]               out_data;
  logic                                out_tail;
  logic [GW-1:0]                       grant_id;

  modport master (
    input  in_empty, in_data, in_tail, out_ready,
    output in_pop, out_valid, out_data, out_tail, grant_id
  );

  modport slave (
    output in_empty, in_data, in_tail, out_ready,
    input  in_pop, out_valid, out_data, out_tail, grant_id
  );
endinterface

// File: rtl/output_port_arbiter.sv
// Packet-locked round-robin arbiter for N_INPUTS FIFOs sharing one output link.
// An input keeps the link from its grant until its tail flit transfers.
// Optional feature macro: ARB_PKT_COUNT_EN adds a saturating 16-bit
// completed-packet counter on port pkt_count.
module output_port_arbiter #(
  parameter int N_INPUTS   = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  output_port_arbiter_if.master  bus
`ifdef ARB_PKT_COUNT_EN
  ,
  output logic [15:0]            pkt_count
`endif
);

  localparam int GW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int SW = GW + 1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                state_r;
  logic [GW-1:0]         grant_id_r;
  logic [GW-1:0]         rr_ptr_r;
  logic [GW-1:0]         winner_s;
  logic                  found_s;
  logic [GW-1:0]         rr_next_s;
  logic                  head_valid_s;
  logic [DATA_WIDTH-1:0] head_data_s;
  logic                  head_tail_s;
  logic                  xfer_s;
  logic                  tail_xfer_s;

  // Round-robin search: first non-empty input at or above rr_ptr, wrapping.
  always_comb begin
    logic [SW-1:0] sum_v;
    logic [GW-1:0] idx_v;
    winner_s = rr_ptr_r;
    found_s  = 1'b0;
    sum_v    = '0;
    idx_v    = '0;
    for (int k = 0; k < N_INPUTS; k++) begin
      sum_v = {1'b0, rr_ptr_r} + SW'(k);
      if (sum_v >= SW'(N_INPUTS)) begin
        sum_v = sum_v - SW'(N_INPUTS);
      end else begin
        sum_v = sum_v;
      end
      idx_v = sum_v[GW-1:0];
      if (!found_s && !bus.in_empty[idx_v]) begin
        found_s  = 1'b1;
        winner_s = idx_v;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Head flit of the granted FIFO and the resulting transfer conditions.
  always_comb begin
    head_valid_s = ~bus.in_empty[grant_id_r];
    head_data_s  = bus.in_data[grant_id_r];
    head_tail_s  = bus.in_tail[grant_id_r];
    xfer_s       = (state_r == LOCKED) && head_valid_s && bus.out_ready;
    tail_xfer_s  = xfer_s && head_tail_s;
    if (grant_id_r == GW'(N_INPUTS - 1)) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = grant_id_r + GW'(1);
    end
  end

  // Link-side outputs pass the owner's head straight through; quiet when idle.
  always_comb begin
    bus.in_pop    = '0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_tail  = 1'b0;
    bus.grant_id  = grant_id_r;
    if (state_r == LOCKED) begin
      bus.out_valid = head_valid_s;
      bus.out_data  = head_data_s;
      bus.out_tail  = head_tail_s;
    end else begin
      bus.out_valid = 1'b0;
    end
    if (xfer_s) begin
      bus.in_pop[grant_id_r] = 1'b1;
    end else begin
      bus.in_pop = '0;
    end
  end

  // Ownership FSM: arbitrate in IDLE, hold the lock until the tail transfers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      grant_id_r <= '0;
      rr_ptr_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            grant_id_r <= winner_s;
            state_r    <= LOCKED;
          end else begin
            state_r    <= IDLE;
          end
        end
        LOCKED: begin
          if (tail_xfer_s) begin
            state_r  <= IDLE;
            rr_ptr_r <= rr_next_s;
          end else begin
            state_r  <= LOCKED;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef ARB_PKT_COUNT_EN
  logic [15:0] pkt_count_r;

  // Count completed packets, sticking at the maximum.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count_r <= 16'h0000;
    end else if (tail_xfer_s && (pkt_count_r != 16'hFFFF)) begin
      pkt_count_r <= pkt_count_r + 16'h0001;
    end else begin
      pkt_count_r <= pkt_count_r;
    end
  end

  assign pkt_count = pkt_count_r;
`endif

endmodule

// File: tb/tb_output_port_arbiter.sv
// Self-checking bench for output_port_arbiter: FIFOs modelled as queues,
// expected link behaviour computed per cycle from the ownership rules.
module tb_output_port_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int GW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          tail;
  } flit_t;

  logic clk;
  logic reset;
  output_port_arbiter_if #(.N_INPUTS(N), .DATA_WIDTH(DW)) bus ();
`ifdef ARB_PKT_COUNT_EN
  logic [15:0] pkt_count;
`endif

  output_port_arbiter #(.N_INPUTS(N), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ARB_PKT_COUNT_EN
    ,
    .pkt_count (pkt_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_cmp  = 0;
  int    n_fail = 0;
  flit_t q[N][$];
  int    owner_m = -1;
  int    rr_m    = 0;
  int    cnt_m   = 0;
  int    tails_obs[$];

`define CHK(TAG, OBS, EXP) \
  begin \
    n_cmp++; \
    assert ((OBS) === (EXP)) else begin \
      n_fail++; \
      $error("FAIL %s observed=%0h expected=%0h", TAG, (OBS), (EXP)); \
    end \
  end

  task automatic push_pkt(input int i, input int len);
    flit_t f;
    for (int j = 0; j < len; j++) begin
      f.data = {$urandom, $urandom};
      f.tail = (j == len - 1);
      q[i].push_back(f);
    end
  endtask

  // Idle-state check: quiet link outputs and FSM in IDLE.
  task automatic check_idle(input string tag);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_pop !== '0 || bus.out_tail !== 1'b0 ||
        bus.out_data !== '0 || dut.state_r !== 1'b0) begin
      n_fail++;
      $error("FAIL %s idle state: out_valid=%0b in_pop=%0h out_tail=%0b out_data=%0h state=%0b",
             tag, bus.out_valid, bus.in_pop, bus.out_tail, bus.out_data, dut.state_r);
    end
  endtask

  // One clock: drive FIFO heads, check outputs at negedge, advance the model.
  task automatic cycle(input bit rst, input bit rdy);
    bit            rdy_e;
    bit            ev;
    logic [DW-1:0] ed;
    bit            et;
    logic [N-1:0]  ep;
    bit            found;
    flit_t         f;
    rdy_e = rst ? 1'b0 : rdy;
    reset = rst;
    for (int i = 0; i < N; i++) begin
      bus.in_empty[i] = (q[i].size() == 0);
      bus.in_data[i]  = (q[i].size() != 0) ? q[i][0].data : '0;
      bus.in_tail[i]  = (q[i].size() != 0) ? q[i][0].tail : 1'b0;
    end
    bus.out_ready = rdy_e;
    @(negedge clk);
    ev = 1'b0; ed = '0; et = 1'b0; ep = '0;
    if (owner_m >= 0 && q[owner_m].size() != 0) begin
      ev = 1'b1;
      ed = q[owner_m][0].data;
      et = q[owner_m][0].tail;
      if (rdy_e) ep[owner_m] = 1'b1;
    end
    `CHK("out_valid", bus.out_valid, ev)
    `CHK("out_data", bus.out_data, ed)
    `CHK("out_tail", bus.out_tail, et)
    `CHK("in_pop", bus.in_pop, ep)
    `CHK("rr_ptr", dut.rr_ptr_r, GW'(rr_m))
    if (owner_m >= 0) `CHK("grant_id", bus.grant_id, GW'(owner_m))
`ifdef ARB_PKT_COUNT_EN
    `CHK("pkt_count", pkt_count, 16'(cnt_m))
`endif
    if (bus.in_pop != '0 && bus.out_tail) tails_obs.push_back(int'(bus.grant_id));
    @(posedge clk);
    if (rst) begin
      owner_m = -1; rr_m = 0; cnt_m = 0;
    end else if (owner_m < 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && q[(rr_m + k) % N].size() != 0) begin
          found = 1'b1;
          owner_m = (rr_m + k) % N;
        end
      end
    end else if (q[owner_m].size() != 0 && rdy_e) begin
      f = q[owner_m].pop_front();
      if (f.tail) begin
        rr_m = (owner_m + 1) % N;
        owner_m = -1;
        if (cnt_m < 65535) cnt_m++;
      end
    end
    #1;
  endtask

  function automatic bit model_busy();
    bit b;
    b = (owner_m >= 0);
    for (int i = 0; i < N; i++) if (q[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  // Bounded wait until all queued traffic has left; expiry is a failure.
  task automatic drain(input int max_cycles);
    int waited;
    waited = 0;
    while (model_busy() && waited < max_cycles) begin
      cycle(1'b0, 1'b1);
      waited++;
    end
    n_cmp++;
    if (model_busy()) begin
      n_fail++;
      $error("FAIL drain wait expired after %0d cycles", max_cycles);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.in_empty = '1;
    bus.in_data = '0;
    bus.in_tail = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset held, then all inputs empty for 10 cycles: nothing happens.
    cycle(1'b1, 1'b0);
    check_idle("after_reset");
    repeat (10) begin
      cycle(1'b0, 1'b1);
      check_idle("all_empty");
    end

    // Single-flit packets on all inputs: grants 0,1,2,3 and pointer wraps.
    for (int i = 0; i < N; i++) push_pkt(i, 1);
    tails_obs.delete();
    repeat (10) cycle(1'b0, 1'b1);
    `CHK("order_len", tails_obs.size(), 4)
    for (int i = 0; i < 4; i++) if (i < tails_obs.size()) `CHK("order_032", tails_obs[i], i)

    // Input 2 mid-packet blocks a later request from input 1.
    tails_obs.delete();
    push_pkt(2, 3);
    repeat (2) cycle(1'b0, 1'b1);
    push_pkt(1, 1);
    repeat (8) cycle(1'b0, 1'b1);
    `CHK("order_033_len", tails_obs.size(), 2)
    if (tails_obs.size() == 2) begin
      `CHK("order_033_a", tails_obs[0], 2)
      `CHK("order_033_b", tails_obs[1], 1)
    end

    // Bubble in the granted FIFO holds the lock against other requesters.
    tails_obs.delete();
    push_pkt(0, 1);
    q[0][0].tail = 1'b0;
    repeat (2) cycle(1'b0, 1'b1);
    push_pkt(1, 2);
    push_pkt(3, 1);
    repeat (3) cycle(1'b0, 1'b1);
    push_pkt(0, 1);
    repeat (12) cycle(1'b0, 1'b1);
    `CHK("order_034_len", tails_obs.size(), 3)
    if (tails_obs.size() > 0) `CHK("order_034_first", tails_obs[0], 0)

    // Backpressure: five stalled cycles with a valid flit.
    push_pkt(2, 2);
    cycle(1'b0, 1'b1);
    repeat (5) cycle(1'b0, 1'b0);
    repeat (4) cycle(1'b0, 1'b1);

    // Reset after flit 2 of a 4-flit packet; leftovers go out as a new grant.
    push_pkt(1, 4);
    repeat (3) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    check_idle("after_mid_packet_reset");
    `CHK("rr_after_reset", dut.rr_ptr_r, 2'd0)
    repeat (6) cycle(1'b0, 1'b1);
`ifdef ARB_PKT_COUNT_EN
    `CHK("pkt_count_after", pkt_count, 16'd1)
`endif

    // Random traffic, backpressure and occasional resets.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        int i;
        i = $urandom_range(0, N - 1);
        if (q[i].size() < 8) push_pkt(i, $urandom_range(1, 4));
      end
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0);
    end
    drain(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/output_port_arbiter.md
OUTPUT_PORT_ARBITER -- requirements
Module: output_port_arbiter

Interface
REQ-001 Parameter N_INPUTS, default 4, number of input FIFOs competing for the output link; legal range 2..8.
REQ-002 Parameter DATA_WIDTH, default 64, flit width in bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 in_empty  input  N_INPUTS  per-input FIFO empty flag; bit i high = FIFO i holds no flit.
REQ-006 in_data  input  N_INPUTS x DATA_WIDTH  per-input FIFO head flit (first-word-fall-through dout).
REQ-007 in_tail  input  N_INPUTS  per-input flag, high when the head flit of FIFO i is the last flit of its packet.
REQ-008 in_pop  output  N_INPUTS  per-input FIFO pop strobe; at most one bit high per cycle.
REQ-009 out_valid  output  1  out_data carries a valid flit this cycle.
REQ-010 out_ready  input  1  downstream accepts the flit this cycle.
REQ-011 out_data  output  DATA_WIDTH  flit forwarded to the output link.
REQ-012 out_tail  output  1  out_data is a tail flit.
REQ-013 grant_id  output  clog2(N_INPUTS)  index of the input currently owning the link; valid only while locked.

Function
REQ-014 FSM SHALL have two states: IDLE (no owner) and LOCKED (one input owns the link until its tail flit transfers).
REQ-015 In IDLE: if any in_empty bit is low, winner = first non-empty input scanning from rr_ptr upward modulo N_INPUTS; grant_id <= winner, state <= LOCKED on next edge.
REQ-016 In IDLE: out_valid = 0, in_pop = 0; arbitration costs exactly one cycle before the first flit can transfer.
REQ-017 In LOCKED: out_valid = ~in_empty[grant_id]; out_data = in_data[grant_id]; out_tail = in_tail[grant_id]; all combinational, zero added latency.
REQ-018 Transfer occurs when out_valid & out_ready; in_pop[grant_id] SHALL equal that transfer condition; all other in_pop bits 0.
REQ-019 In LOCKED, an empty granted FIFO (mid-packet bubble) SHALL hold the lock; requests from other inputs are ignored until the tail transfers.
REQ-020 Transfer with out_tail = 1: state <= IDLE, rr_ptr <= (grant_id + 1) mod N_INPUTS, wrapping from N_INPUTS-1 to 0.
REQ-021 Transfer with out_tail = 0, or no transfer: state, grant_id, rr_ptr unchanged.
REQ-022 Single-flit packet (head is also tail) SHALL be granted, transferred in one LOCKED cycle, and release the lock on that edge.
REQ-023 out_valid SHALL NOT depend on out_ready; out_data and out_tail SHALL stay stable while out_valid & ~out_ready.
REQ-024 rr_ptr SHALL only change on tail transfer; a grant never starves an input for more than N_INPUTS-1 other packets.

Reset
REQ-025 On reset: state <= IDLE, rr_ptr <= 0, grant_id <= 0; in the cycle after, in_pop = 0, out_valid = 0, out_tail = 0, out_data = 0.
REQ-026 Reset asserted mid-packet SHALL abandon the lock; no pop issued in the reset cycle's following cycle; partially sent packet is not resumed.
REQ-027 Reset SHALL take priority over every transfer and arbitration event in the same cycle.

Configuration
REQ-028 Macro ARB_PKT_COUNT_EN SHALL control an extra output pkt_count (16 bits, output).
REQ-029 With ARB_PKT_COUNT_EN defined: pkt_count increments by 1 on each tail transfer, saturates at 16'hFFFF, resets to 0.
REQ-030 Without ARB_PKT_COUNT_EN: port pkt_count and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-031 Reset, all in_empty = 4'b1111 for 10 cycles -> out_valid = 0, in_pop = 0, state IDLE throughout.
REQ-032 Inputs 0..3 each hold a 1-flit packet, out_ready = 1 -> grants in order 0,1,2,3, each packet out 2 cycles apart, rr_ptr wraps to 0.
REQ-033 Input 2 sends 3-flit packet, input 1 requests after flit 1 -> input 1 granted only after input 2 tail transfers; rr_ptr = 3 then winner 1 next.
REQ-034 Granted FIFO goes empty after flit 1 for 3 cycles, other inputs non-empty -> out_valid = 0, lock held, flit 2 forwarded when refilled.
REQ-035 out_ready = 0 for 5 cycles while out_valid = 1 -> in_pop = 0 and out_data constant; pop fires on first ready cycle.
REQ-036 reset pulsed after flit 2 of a 4-flit packet -> next cycle IDLE, out_valid = 0, rr_ptr = 0; with ARB_PKT_COUNT_EN, pkt_count = 0 and counts 1 after the next tail.
